stage_ctrl_out_ctrl_param: RTL
==============================

Name: stage_ctrl_out_ctrl_param

Overview:
Parametrised next-generation stage output controller for the neural pipeline stage. It sits between the stage datapath (tap/bias/data compute) and the tap/bias memories. It generates tap and bias read/write control, delays error-update write-backs through configurable pipelines, and arbitrates write-back against incoming error updates with a replay register instead of silently dropping them. It drives the stage data and error outputs through valid/ready skid buffers.

Parameters:
NUM_TAPS, 12, taps per memory row
DATA_W, 32, word width (float_24_8 packed)
ADDR_W, 5, tap/bias memory address width
TAP_BASE, 12, base row of error-phase tap rows
WB_DELAY, 5, cycles from write-back request to tap write (>=2)
ERR_DELAY, 16, cycles from error-update-remove to error output valid (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
active_normal  in  1  normal-mode memory read enable
tap_address  in  ADDR_W  normal tap/bias read row
bias_wr_address  in  ADDR_W  bias write row
error_phase, error_phase_read  in  4  error write/read phase
error_update_first, error_update_latch, error_tap_update_out  in  1  update control
error_valid  in  1  error sub-word update request
error_sub_address, error_value  in  DATA_W  sub-word update address/data
tap_enable, bias_enable  in  1  write-back enables
st_tap_out  in  NUM_TAPS*DATA_W  updated taps from datapath
st_bias_out, st_data_out, st_data_out_pre  in  DATA_W  datapath results
st_data_vld  in  1  st_data_out valid
tap_int_rd_address, tap_int_wr_address  out  ADDR_W
tap_int_rd_vld, tap_int_wr_vld, tap_int_sub_vld  out  1
tap_int_sub_addr, tap_int_sub_data  out  DATA_W
tap_int_wr_data  out  NUM_TAPS*DATA_W
bias_int_rd_address, bias_int_wr_address  out  ADDR_W
bias_int_rd_vld, bias_int_wr_vld  out  1
bias_int_wr_data  out  DATA_W
stage_data_out  out  DATA_W;  stage_data_out_vld  out  1;  stage_data_out_rdy  in  1
zerror_int  out  DATA_W;  zerror_int_vld  out  1;  zerror_int_rdy  in  1
stage_error_back  out  1  = error_tap_update_out
wb_busy  out  1  write-back in flight
ovf_err  out  1  sticky skid-overflow flag

Behaviour:
- Reset (reset=0, async): all delay lines, skid buffers, replay register, and counters clear; all *_vld outputs 0; ovf_err=0; wb_busy=0; FSM=IDLE.
- Read: tap_int_rd_address = error_update_first ? TAP_BASE+error_phase_read (zero-extended, modulo 2^ADDR_W) : tap_address. tap_int_rd_vld = bias_int_rd_vld = active_normal. bias_int_rd_address = tap_address.
- Write-back request wb_req = error_update_latch & ~error_update_first. wb_req and rd_address are delayed WB_DELAY cycles (wb_d, addr_d). upd_d = error_tap_update_out delayed WB_DELAY.
- Tap write, priority: (1) wb_d -> wr_address=addr_d, wr_vld=tap_enable&~upd_d, sub_vld=0; (2) replay register full -> replay entry, sub_vld=1; (3) error_valid -> TAP_BASE+error_phase, sub_vld=1. wr_data=st_tap_out; sub_addr/sub_data from the winning source.
- Collision: error_valid in a cycle taken by (1) or (2) is captured into the 1-entry replay register and issued on the next free cycle. A further collision while replay is full sets ovf_err; the new update is dropped.
- Bias write: bias_int_wr_vld = bias_enable & wb_req delayed WB_DELAY-1; wr_address=bias_wr_address; wr_data=st_bias_out.
- wb_busy = in-flight counter != 0. The counter increments on wb_req, decrements on the wb_d issue, and holds when both occur in the same cycle.
- FSM IDLE->ACTIVE on wb_req or error_valid. ACTIVE->DRAIN when error_tap_update_out falls. DRAIN->IDLE when the counter is 0 and replay is empty. error_valid in DRAIN returns the FSM to ACTIVE.
- Error output: err_rm = error_tap_update_out & ~error_update_first, delayed ERR_DELAY cycles. It pushes st_data_out_pre into a 2-entry error skid FIFO. zerror_int/zerror_int_vld come from the FIFO head; pop on vld&rdy. Push and pop in the same cycle are allowed. A push while full sets ovf_err and drops the data.
- Data output: st_data_vld pushes st_data_out into a 2-entry skid FIFO with identical rules. With rdy held at 1, latency is 1 cycle.

Optional Feature:
STAGE_CTRL_PERF_EN: adds outputs perf_wb_cnt[15:0] (tap write-backs issued) and perf_coll_cnt[15:0] (collisions captured). Both saturate at 0xFFFF and clear on reset. Without the macro, these ports and counters do not exist.

Test Plan:
- Read mux: error_update_first=1, error_phase_read=3 -> tap_int_rd_address=15. Then first=0, tap_address=7 -> 7.
- Write-back: error_update_latch=1 at T0 with rd row 9, tap_enable=1, update_out=0 -> tap wr_vld=1, addr 9 at T0+5; bias wr_vld at T0+4.
- Collision: error_valid at T0+5 alongside the write-back -> replay issues at T0+6 with sub_vld=1, addr TAP_BASE+phase. A second collision while replay is full -> ovf_err=1.
- Error delay: err_rm pulse at T0, zerror_int_rdy=1 -> zerror_int_vld at T0+16 with the captured st_data_out_pre.
- Backpressure: stage_data_out_rdy=0, three st_data_vld pulses -> first two held in order, ovf_err=1 on the third. Raising rdy drains both.
- Async reset asserted mid write-back -> all vld outputs 0 immediately, wb_busy=0, no write issued after release.

Source files
------------

// File: rtl/stage_ctrl_out_ctrl_param.sv
// ---------------------------------------------------------------------------
// stage_ctrl_out_ctrl_param
//
// Output controller for one neural pipeline stage. It sits between the stage
// datapath (tap/bias/data compute) and the tap/bias memories:
//   - muxes the tap read row between normal rows and error-phase rows
//   - delays error-update write-backs by WB_DELAY cycles (bias by WB_DELAY-1)
//   - arbitrates delayed write-backs against incoming sub-word error updates,
//     parking a colliding update in a one-entry replay register
//   - delays the error-remove strobe and queues the error result, and queues
//     the stage data result, each through a 2-entry valid/ready skid FIFO
//
// Optional build macro: STAGE_CTRL_PERF_EN adds saturating 16-bit counters
// perf_wb_cnt (tap write-backs issued) and perf_coll_cnt (collisions captured).
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   active_normal                   normal-mode memory read enable
//   tap_address, bias_wr_address    normal read row / bias write row
//   error_phase, error_phase_read   error write / read phase
//   error_update_first/_latch       update sequencing controls
//   error_tap_update_out            update-out strobe (also stage_error_back)
//   error_valid, error_sub_address, error_value   sub-word update request
//   tap_enable, bias_enable         write-back enables
//   st_tap_out, st_bias_out         updated taps / bias from the datapath
//   st_data_out(_pre), st_data_vld  datapath results
//   tap_int_*, bias_int_*           tap / bias memory control
//   stage_data_out*, zerror_int*    valid/ready result streams
//   wb_busy                         a write-back is in flight
//   ovf_err                         sticky overflow (replay or skid FIFO)
// ---------------------------------------------------------------------------

// Two-entry skid FIFO. A push while full is accepted only when the head is
// popped in the same cycle; otherwise it is dropped and ovf_o pulses.
module StageCtrlSkidFifo #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         rdy_i,
   output logic [W-1:0] dout_o,
   output logic         vld_o,
   output logic         ovf_o
);

   logic [1:0]   count_q;
   logic [W-1:0] mem0_q;
   logic [W-1:0] mem1_q;
   logic         pop;
   logic         accept;

   assign vld_o  = (count_q != 2'd0);
   assign dout_o = mem0_q;
   assign pop    = vld_o & rdy_i;
   assign accept = push_i & ((count_q != 2'd2) | pop);
   assign ovf_o  = push_i & ~accept;

   // mem0 is always the head; a pop shifts mem1 forward
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= 2'd0;
         mem0_q  <= '0;
         mem1_q  <= '0;
      end else begin
         case ({accept, pop})
            2'b10: begin
               if (count_q == 2'd0) mem0_q <= din_i;
               else                 mem1_q <= din_i;
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               mem0_q  <= mem1_q;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  mem0_q <= din_i;
               end else begin
                  mem0_q <= mem1_q;
                  mem1_q <= din_i;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

module stage_ctrl_out_ctrl_param #(
   parameter int NUM_TAPS  = 12,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int TAP_BASE  = 12,
   parameter int WB_DELAY  = 5,
   parameter int ERR_DELAY = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       active_normal,
   input  logic [ADDR_W-1:0]          tap_address,
   input  logic [ADDR_W-1:0]          bias_wr_address,
   input  logic [3:0]                 error_phase,
   input  logic [3:0]                 error_phase_read,
   input  logic                       error_update_first,
   input  logic                       error_update_latch,
   input  logic                       error_tap_update_out,
   input  logic                       error_valid,
   input  logic [DATA_W-1:0]          error_sub_address,
   input  logic [DATA_W-1:0]          error_value,
   input  logic                       tap_enable,
   input  logic                       bias_enable,
   input  logic [NUM_TAPS*DATA_W-1:0] st_tap_out,
   input  logic [DATA_W-1:0]          st_bias_out,
   input  logic [DATA_W-1:0]          st_data_out,
   input  logic [DATA_W-1:0]          st_data_out_pre,
   input  logic                       st_data_vld,
   output logic [ADDR_W-1:0]          tap_int_rd_address,
   output logic [ADDR_W-1:0]          tap_int_wr_address,
   output logic                       tap_int_rd_vld,
   output logic                       tap_int_wr_vld,
   output logic                       tap_int_sub_vld,
   output logic [DATA_W-1:0]          tap_int_sub_addr,
   output logic [DATA_W-1:0]          tap_int_sub_data,
   output logic [NUM_TAPS*DATA_W-1:0] tap_int_wr_data,
   output logic [ADDR_W-1:0]          bias_int_rd_address,
   output logic [ADDR_W-1:0]          bias_int_wr_address,
   output logic                       bias_int_rd_vld,
   output logic                       bias_int_wr_vld,
   output logic [DATA_W-1:0]          bias_int_wr_data,
   output logic [DATA_W-1:0]          stage_data_out,
   output logic                       stage_data_out_vld,
   input  logic                       stage_data_out_rdy,
   output logic [DATA_W-1:0]          zerror_int,
   output logic                       zerror_int_vld,
   input  logic                       zerror_int_rdy,
   output logic                       stage_error_back,
   output logic                       wb_busy,
   output logic                       ovf_err
`ifdef STAGE_CTRL_PERF_EN
   ,
   output logic [15:0]                perf_wb_cnt,
   output logic [15:0]                perf_coll_cnt
`endif
);

   localparam int CNT_W = $clog2(WB_DELAY + 1) + 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;

   logic [ADDR_W-1:0] rdRow;
   logic [ADDR_W-1:0] errRow;
   logic              wbReq;
   logic              errRm;

   logic [WB_DELAY-1:0] wbPipe_q;
   logic [WB_DELAY-1:0] updPipe_q;
   logic [ADDR_W-1:0]   addrPipe_q [WB_DELAY];
   logic                wbD;
   logic                updD;
   logic [ADDR_W-1:0]   addrD;

   logic              replayFull_q, replayFull_d;
   logic [ADDR_W-1:0] replayRow_q, replayRow_d;
   logic [DATA_W-1:0] replayAddr_q, replayAddr_d;
   logic [DATA_W-1:0] replayData_q, replayData_d;
   logic              collCapture;
   logic              collDrop;
   logic              subVldRaw;

   logic [CNT_W-1:0]  inFlight_q;
   logic [1:0]        state_q, state_d;
   logic              updPrev_q;
   logic              ovf_q;
   logic              errPush;
   logic              dataOvf;
   logic              errOvf;

   // Error-phase rows wrap modulo the memory depth.
   assign errRow = ADDR_W'(32'(TAP_BASE) + 32'(error_phase));
   assign rdRow  = error_update_first ? ADDR_W'(32'(TAP_BASE) + 32'(error_phase_read))
                                      : tap_address;

   assign wbReq = error_update_latch & ~error_update_first;
   assign errRm = error_tap_update_out & ~error_update_first;

   // Read side is combinational. Valids are qualified with reset so that the
   // memories see no request while the stage is held in reset.
   assign tap_int_rd_address  = rdRow;
   assign tap_int_rd_vld      = active_normal & reset;
   assign bias_int_rd_address = tap_address;
   assign bias_int_rd_vld     = active_normal & reset;
   assign stage_error_back    = error_tap_update_out;

   // Write-back delay lines: request, read row and update-out strobe travel
   // together so the write lands on the row that was read WB_DELAY cycles ago.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wbPipe_q  <= '0;
         updPipe_q <= '0;
         for (int k = 0; k < WB_DELAY; k++) addrPipe_q[k] <= '0;
      end else begin
         wbPipe_q[0]   <= wbReq;
         updPipe_q[0]  <= error_tap_update_out;
         addrPipe_q[0] <= rdRow;
         for (int k = 1; k < WB_DELAY; k++) begin
            wbPipe_q[k]   <= wbPipe_q[k-1];
            updPipe_q[k]  <= updPipe_q[k-1];
            addrPipe_q[k] <= addrPipe_q[k-1];
         end
      end
   end

   assign wbD   = wbPipe_q[WB_DELAY-1];
   assign updD  = updPipe_q[WB_DELAY-1];
   assign addrD = addrPipe_q[WB_DELAY-1];

   // The bias write leads the tap write by one cycle.
   assign bias_int_wr_vld     = bias_enable & wbPipe_q[WB_DELAY-2];
   assign bias_int_wr_address = bias_wr_address;
   assign bias_int_wr_data    = st_bias_out;
   assign tap_int_wr_data     = st_tap_out;

   // Tap write port arbitration: delayed write-back, then a parked replay,
   // then a fresh sub-word update. A fresh update that loses is parked if the
   // replay slot is free (or is being drained this cycle), otherwise dropped.
   always_comb begin
      tap_int_wr_address = '0;
      tap_int_wr_vld     = 1'b0;
      subVldRaw          = 1'b0;
      tap_int_sub_addr   = '0;
      tap_int_sub_data   = '0;
      replayFull_d       = replayFull_q & wbD;
      replayRow_d        = replayRow_q;
      replayAddr_d       = replayAddr_q;
      replayData_d       = replayData_q;
      collCapture        = 1'b0;
      collDrop           = 1'b0;

      if (wbD) begin
         tap_int_wr_address = addrD;
         tap_int_wr_vld     = tap_enable & ~updD;
      end else if (replayFull_q) begin
         tap_int_wr_address = replayRow_q;
         subVldRaw          = 1'b1;
         tap_int_sub_addr   = replayAddr_q;
         tap_int_sub_data   = replayData_q;
      end else if (error_valid) begin
         tap_int_wr_address = errRow;
         subVldRaw          = 1'b1;
         tap_int_sub_addr   = error_sub_address;
         tap_int_sub_data   = error_value;
      end

      if (error_valid && (wbD || replayFull_q)) begin
         if (wbD && replayFull_q) begin
            collDrop = 1'b1;
         end else begin
            collCapture  = 1'b1;
            replayFull_d = 1'b1;
            replayRow_d  = errRow;
            replayAddr_d = error_sub_address;
            replayData_d = error_value;
         end
      end
   end

   assign tap_int_sub_vld = subVldRaw & reset;

   // Replay register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         replayFull_q <= 1'b0;
         replayRow_q  <= '0;
         replayAddr_q <= '0;
         replayData_q <= '0;
      end else begin
         replayFull_q <= replayFull_d;
         replayRow_q  <= replayRow_d;
         replayAddr_q <= replayAddr_d;
         replayData_q <= replayData_d;
      end
   end

   // In-flight write-back counter; a request and an issue in the same cycle
   // cancel out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inFlight_q <= '0;
      end else begin
         case ({wbReq, wbD})
            2'b10:   inFlight_q <= inFlight_q + CNT_W'(1);
            2'b01:   inFlight_q <= inFlight_q - CNT_W'(1);
            default: ;
         endcase
      end
   end

   assign wb_busy = (inFlight_q != '0);

   // Sequencing FSM tracking the update window; DRAIN waits for all
   // write-back traffic (pipeline and replay) to retire.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (wbReq || error_valid) state_d = ST_ACTIVE;
         ST_ACTIVE: if (updPrev_q && !error_tap_update_out) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (error_valid)                                state_d = ST_ACTIVE;
            else if (inFlight_q == '0 && !replayFull_q)     state_d = ST_IDLE;
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         updPrev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         updPrev_q <= error_tap_update_out;
      end
   end

   // Error-remove delay. The skid FIFO adds one register stage, so the line
   // is one shorter than ERR_DELAY to make zerror_int_vld rise exactly
   // ERR_DELAY cycles after the strobe.
   generate
      if (ERR_DELAY > 1) begin : gErrPipe
         localparam int ED = ERR_DELAY - 1;
         logic [ED-1:0] errPipe_q;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               errPipe_q <= '0;
            end else begin
               errPipe_q[0] <= errRm;
               for (int k = 1; k < ED; k++) errPipe_q[k] <= errPipe_q[k-1];
            end
         end
         assign errPush = errPipe_q[ED-1];
      end else begin : gErrDirect
         assign errPush = errRm;
      end
   endgenerate

   StageCtrlSkidFifo #(.W(DATA_W)) uErrFifo (
      .clk    (clk),
      .reset  (reset),
      .push_i (errPush),
      .din_i  (st_data_out_pre),
      .rdy_i  (zerror_int_rdy),
      .dout_o (zerror_int),
      .vld_o  (zerror_int_vld),
      .ovf_o  (errOvf)
   );

   StageCtrlSkidFifo #(.W(DATA_W)) uDataFifo (
      .clk    (clk),
      .reset  (reset),
      .push_i (st_data_vld),
      .din_i  (st_data_out),
      .rdy_i  (stage_data_out_rdy),
      .dout_o (stage_data_out),
      .vld_o  (stage_data_out_vld),
      .ovf_o  (dataOvf)
   );

   // Sticky overflow: any dropped update or dropped result
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ovf_q <= 1'b0;
      else        ovf_q <= ovf_q | collDrop | errOvf | dataOvf;
   end

   assign ovf_err = ovf_q;

`ifdef STAGE_CTRL_PERF_EN
   // Saturating performance counters
   logic [15:0] perfWb_q;
   logic [15:0] perfColl_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perfWb_q   <= '0;
         perfColl_q <= '0;
      end else begin
         if (tap_int_wr_vld && perfWb_q != 16'hFFFF) perfWb_q   <= perfWb_q + 16'd1;
         if (collCapture && perfColl_q != 16'hFFFF)  perfColl_q <= perfColl_q + 16'd1;
      end
   end

   assign perf_wb_cnt   = perfWb_q;
   assign perf_coll_cnt = perfColl_q;
`else
   // Default build carries no performance counters.
`endif

endmodule
